bcd_updown_counter_seg: RTL and testbench
=========================================

BCD_UPDOWN_COUNTER_SEG -- requirements
Module: bcd_updown_counter_seg

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of cascaded BCD decades (1..8).
REQ-002 SHALL have parameter RST_VAL, default 0, decimal reset/clear value, range 0..10^DIGITS-1.
REQ-003 SHALL have port CP  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port D  input  4*DIGITS  parallel-load BCD value, digit 0 = D[3:0].
REQ-006 SHALL have port PEn  input  1  synchronous parallel load, active low.
REQ-007 SHALL have port MRn  input  1  synchronous clear to RST_VAL, active low.
REQ-008 SHALL have port CEP  input  1  count enable, parallel.
REQ-009 SHALL have port CET  input  1  count enable, trickle; also gates TC.
REQ-010 SHALL have port UD  input  1  count direction: 1 = up, 0 = down.
REQ-011 SHALL have port LTN  input  1  lamp test, active low.
REQ-012 SHALL have port BIN  input  1  blank all digits, active low.
REQ-013 SHALL have port RBIN  input  1  ripple-blank input to the most significant digit, active low.
REQ-014 SHALL have port Q  output  4*DIGITS  registered BCD count.
REQ-015 SHALL have port TC  output  1  terminal count, combinational.
REQ-016 SHALL have port RBON  output  1  ripple-blank output of digit 0, active low.
REQ-017 SHALL have port o_Z  output  7*DIGITS  segments; digit i = o_Z[7i+6:7i] = {a,b,c,d,e,f,g}, active low.

Function
REQ-018 SHALL apply per-CP-edge priority: rst > MRn=0 > PEn=0 > (CEP&CET) count > hold.
REQ-019 SHALL make rst=1 and MRn=0 both load RST_VAL into Q on the next edge.
REQ-020 SHALL make PEn=0 load D into Q on the next edge, with any D digit >9 stored as 9.
REQ-021 SHALL count up by decimal +1 per enabled edge when UD=1, each digit 9->0 carrying into the next digit.
REQ-022 SHALL count down by decimal -1 per enabled edge when UD=0, each digit 0->9 borrowing from the next digit.
REQ-023 SHALL wrap up from all-9s to all-0s, and down from all-0s to all-9s.
REQ-024 SHALL drive TC=1 when CET=1 and Q is all-9s (UD=1) or all-0s (UD=0), otherwise 0; TC ignores CEP.
REQ-025 SHALL take a UD change effect on the next enabled edge, with TC updating combinationally in the same cycle.
REQ-026 SHALL hold Q when CEP=0 or CET=0 and no higher-priority operation is active.
REQ-027 SHALL decode o_Z combinationally from Q with per-digit priority: BIN=0 all segments off (1111111) > LTN=0 all on (0000000) > ripple blank > digit pattern.
REQ-028 SHALL blank digit i when its value is 0, its ripple-blank input is 0, LTN=1 and BIN=1; its ripple-blank output is then 0, otherwise 1.
REQ-029 SHALL feed the ripple-blank input of digit DIGITS-1 from RBIN and of digit i from digit i+1's ripple-blank output; RBON SHALL be digit 0's ripple-blank output.
REQ-030 SHALL use these segment patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-031 SHALL keep BIN and LTN display-only, with no effect on Q or TC.

Reset
REQ-032 SHALL make Q=RST_VAL one edge after rst=1, then o_Z and TC follow combinationally.
REQ-033 SHALL abandon any load or count that coincides with rst=1, with rst taking effect on that same edge.
REQ-034 SHALL leave Q unknown until the first reset edge, and no asynchronous path SHALL exist.

Verification
REQ-035 SHALL be verified with DIGITS=2, RST_VAL=0: rst for 2 edges -> Q=8'h00, TC=1 when UD=0 and CET=1, o_Z digit0=0000001.
REQ-036 SHALL be verified with PEn=0, D=8'h06, then UD=0, CEP=CET=1 for 7 edges -> Q=05,04,03,02,01,00,99; TC=1 only while Q=00.
REQ-037 SHALL be verified with Q=8'h99, UD=1, one enabled edge -> Q=8'h00; the same with CET=0 -> Q holds 99 and TC=0.
REQ-038 SHALL be verified with D=8'hFA loaded -> Q=8'h99.
REQ-039 SHALL be verified with Q=8'h06, RBIN=0 -> digit1 o_Z=1111111, digit0=0100000, RBON=1; with Q=00, RBIN=0 -> both digits blank, RBON=0; then LTN=0 -> all 0000000; then BIN=0 -> all 1111111.
REQ-040 SHALL be verified with rst=1, MRn=0 and PEn=0 asserted together while counting -> Q=RST_VAL next edge, and a later PEn=0 alone loads D.

Source files
------------

// File: rtl/bcd_updown_counter_seg.sv
// Cascaded BCD up/down counter with load and clear, plus 7-segment decode with ripple blanking.
// Latency: Q updates one CP edge after its controls; TC, o_Z and RBON follow Q and the inputs combinationally.
// Backpressure: none; CEP/CET gate counting and the state holds while either is low.
module bcd_updown_counter_seg #(
    parameter int DIGITS  = 2,
    parameter int RST_VAL = 0
) (
    input  logic                  CP,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   D,
    input  logic                  PEn,
    input  logic                  MRn,
    input  logic                  CEP,
    input  logic                  CET,
    input  logic                  UD,
    input  logic                  LTN,
    input  logic                  BIN,
    input  logic                  RBIN,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TC,
    output logic                  RBON,
    output logic [7*DIGITS-1:0]   o_Z
);

    function automatic logic [4*DIGITS-1:0] to_bcd(input int value);
        logic [4*DIGITS-1:0] result;
        int                  rem;
        result = '0;
        rem    = value;
        for (int i = 0; i < DIGITS; i++) begin
            result[4*i +: 4] = 4'(rem % 10);
            rem              = rem / 10;
        end
        return result;
    endfunction

    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_pattern = 7'b0000001;
            4'd1:    seg_pattern = 7'b1001111;
            4'd2:    seg_pattern = 7'b0010010;
            4'd3:    seg_pattern = 7'b0000110;
            4'd4:    seg_pattern = 7'b1001100;
            4'd5:    seg_pattern = 7'b0100100;
            4'd6:    seg_pattern = 7'b0100000;
            4'd7:    seg_pattern = 7'b0001111;
            4'd8:    seg_pattern = 7'b0000000;
            4'd9:    seg_pattern = 7'b0000100;
            default: seg_pattern = 7'b1111111;
        endcase
    endfunction

    localparam logic [4*DIGITS-1:0] RST_BCD = to_bcd(RST_VAL);

    logic [4*DIGITS-1:0] d_clamp;
    logic [4*DIGITS-1:0] q_next;
    logic                at_term;

    // at_term doubles as the carry/borrow chain: a digit steps only when every lower digit sits at its limit.
    always_comb begin
        d_clamp = D;
        q_next  = Q;
        at_term = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (D[4*i +: 4] > 4'd9) begin
                d_clamp[4*i +: 4] = 4'd9;
            end
            if (at_term) begin
                if (UD) begin
                    q_next[4*i +: 4] = (Q[4*i +: 4] >= 4'd9) ? 4'd0 : Q[4*i +: 4] + 4'd1;
                end else begin
                    q_next[4*i +: 4] = (Q[4*i +: 4] == 4'd0) ? 4'd9 : Q[4*i +: 4] - 4'd1;
                end
            end
            at_term = at_term & (UD ? (Q[4*i +: 4] == 4'd9) : (Q[4*i +: 4] == 4'd0));
        end
    end

    assign TC = CET & at_term;

    always_ff @(posedge CP) begin
        if (rst) begin
            Q <= RST_BCD;
        end else if (!MRn) begin
            Q <= RST_BCD;
        end else if (!PEn) begin
            Q <= d_clamp;
        end else if (CEP && CET) begin
            Q <= q_next;
        end
    end

    // Leading-zero blanking ripples from the most significant digit downwards.
    always_comb begin
        logic rb;
        logic blank;
        o_Z   = '1;
        rb    = RBIN;
        blank = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            blank = (Q[4*i +: 4] == 4'd0) && !rb && LTN && BIN;
            if (!BIN) begin
                o_Z[7*i +: 7] = 7'b1111111;
            end else if (!LTN) begin
                o_Z[7*i +: 7] = 7'b0000000;
            end else if (blank) begin
                o_Z[7*i +: 7] = 7'b1111111;
            end else begin
                o_Z[7*i +: 7] = seg_pattern(Q[4*i +: 4]);
            end
            rb = !blank;
        end
        RBON = rb;
    end

endmodule

// File: tb/tb_bcd_updown_counter_seg.sv
// Randomized and directed bench for bcd_updown_counter_seg (DIGITS=2, RST_VAL=0) against a decimal model.
module tb_bcd_updown_counter_seg;

    logic        CP;
    logic        rst;
    logic [7:0]  D;
    logic        PEn, MRn, CEP, CET, UD, LTN, BIN, RBIN;
    logic [7:0]  Q;
    logic        TC;
    logic        RBON;
    logic [13:0] o_Z;

    bcd_updown_counter_seg #(.DIGITS(2), .RST_VAL(0)) dut (
        .CP(CP), .rst(rst), .D(D), .PEn(PEn), .MRn(MRn), .CEP(CEP), .CET(CET),
        .UD(UD), .LTN(LTN), .BIN(BIN), .RBIN(RBIN),
        .Q(Q), .TC(TC), .RBON(RBON), .o_Z(o_Z)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    int n_checks = 0;
    int n_fail   = 0;
    int mq       = 0;   // model count as a plain decimal number 0..99

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp9(input logic [3:0] v);
        return (v > 4'd9) ? 9 : int'(v);
    endfunction

    function automatic logic [7:0] model_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic model_step();
        if (rst || !MRn)       mq = 0;
        else if (!PEn)         mq = clamp9(D[7:4]) * 10 + clamp9(D[3:0]);
        else if (CEP && CET)   mq = UD ? (mq + 1) % 100 : (mq + 99) % 100;
    endtask

    task automatic check_all(input string tag);
        int         tens, ones;
        bit         b1, b0;
        logic [6:0] s1, s0;
        tens = mq / 10;
        ones = mq % 10;
        b1 = (tens == 0) && !RBIN && LTN && BIN;
        b0 = (ones == 0) && b1 && LTN && BIN;
        s1 = !BIN ? 7'h7f : !LTN ? 7'h00 : b1 ? 7'h7f : SEG_TAB[tens];
        s0 = !BIN ? 7'h7f : !LTN ? 7'h00 : b0 ? 7'h7f : SEG_TAB[ones];
        chk({tag, ".Q"},    32'(Q),    32'(model_bcd(mq)));
        chk({tag, ".TC"},   32'(TC),   32'(CET && (UD ? mq == 99 : mq == 0)));
        chk({tag, ".o_Z"},  32'(o_Z),  32'({s1, s0}));
        chk({tag, ".RBON"}, 32'(RBON), 32'(!b0));
    endtask

    task automatic tick(input string tag);
        @(posedge CP);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] down_seq [7];
        down_seq = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99};

        rst = 1'b1; MRn = 1'b1; PEn = 1'b1; CEP = 1'b0; CET = 1'b1; UD = 1'b0;
        LTN = 1'b1; BIN = 1'b1; RBIN = 1'b1; D = 8'h00;
        #1;

        // reset
        tick("rst0");
        tick("rst1");
        chk("rst_q", 32'(Q), 32'h00);
        chk("rst_tc", 32'(TC), 32'h1);
        chk("rst_seg0", 32'(o_Z[6:0]), 32'(7'b0000001));

        // load 06 then count down through the wrap
        rst = 1'b0; PEn = 1'b0; D = 8'h06;
        tick("load06");
        chk("load06_q", 32'(Q), 32'h06);
        PEn = 1'b1; UD = 1'b0; CEP = 1'b1; CET = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick("down");
            chk("down_q", 32'(Q), 32'(down_seq[i]));
            chk("down_tc", 32'(TC), 32'(down_seq[i] == 8'h00));
        end

        // up wrap from 99, then hold with CET low
        UD = 1'b1;
        #1;
        chk("up99_tc", 32'(TC), 32'h1);
        tick("upwrap");
        chk("upwrap_q", 32'(Q), 32'h00);
        PEn = 1'b0; D = 8'h99;
        tick("load99");
        PEn = 1'b1; CET = 1'b0; CEP = 1'b1;
        #1;
        chk("cet0_tc", 32'(TC), 32'h0);
        tick("cet0_hold");
        chk("cet0_q", 32'(Q), 32'h99);

        // load clamp
        PEn = 1'b0; D = 8'hFA;
        tick("clamp");
        chk("clamp_q", 32'(Q), 32'h99);

        // display blanking / lamp test / blank
        D = 8'h06; RBIN = 1'b0;
        tick("disp06");
        chk("disp06_z", 32'(o_Z), 32'({7'b1111111, 7'b0100000}));
        chk("disp06_rbon", 32'(RBON), 32'h1);
        D = 8'h00;
        tick("disp00");
        chk("disp00_z", 32'(o_Z), 32'h3fff);
        chk("disp00_rbon", 32'(RBON), 32'h0);
        LTN = 1'b0;
        #1;
        check_all("ltn");
        chk("ltn_z", 32'(o_Z), 32'h0000);
        BIN = 1'b0;
        #1;
        check_all("bin");
        chk("bin_z", 32'(o_Z), 32'h3fff);
        LTN = 1'b1; BIN = 1'b1; RBIN = 1'b1;

        // reset beats clear and load while counting; later load alone works
        D = 8'h42;
        tick("load42");
        PEn = 1'b1; CEP = 1'b1; CET = 1'b1; UD = 1'b1;
        tick("cnt43");
        chk("cnt43_q", 32'(Q), 32'h43);
        rst = 1'b1; MRn = 1'b0; PEn = 1'b0; D = 8'h77;
        tick("prio");
        chk("prio_q", 32'(Q), 32'h00);
        rst = 1'b0; MRn = 1'b1;
        tick("load77");
        chk("load77_q", 32'(Q), 32'h77);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst  = ($urandom % 50) == 0;
            MRn  = ($urandom % 30) != 0;
            PEn  = ($urandom % 8) != 0;
            CEP  = ($urandom % 5) != 0;
            CET  = ($urandom % 5) != 0;
            UD   = 1'($urandom % 2);
            LTN  = ($urandom % 12) != 0;
            BIN  = ($urandom % 12) != 0;
            RBIN = 1'($urandom % 2);
            D    = 8'($urandom);
            #1;
            check_all("rnd_comb");
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
